// File: rtl/chords_pkg.sv
// Shared definitions for the chord sequencing blocks: field widths, ROM word layout,
// END-marker test and the song reader state encoding.
package chords_pkg;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int ROM_W    = 16;
    localparam int ADV_BIT  = 15;
    localparam int NOTE_LSB = 6;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ROMWAIT,
        ST_ISSUE,
        ST_WAIT_READY,
        ST_DONE
    } reader_state_e;

    function automatic logic [NOTE_W-1:0] word_note(input logic [ROM_W-1:0] w);
        return w[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [ROM_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic word_adv(input logic [ROM_W-1:0] w);
        return w[ADV_BIT];
    endfunction

    // The adv and reserved bits do not take part in the END test.
    function automatic logic is_end_word(input logic [ROM_W-1:0] w);
        return (word_note(w) == '0) && (word_dur(w) == '0);
    endfunction

endpackage

// File: rtl/chord_song_reader_song_rom.sv
// Song ROM: synchronous read, data appears one cycle after the {song, idx} address.
// Reserved bits [14:12] carry arbitrary patterns in some songs; readers ignore them.
module song_rom
    import chords_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                    clk,
    input  logic [SONG_W+IDX_W-1:0] addr_i,
    output logic [ROM_W-1:0]        data_o
);

    function automatic logic [ROM_W-1:0] make_word(input logic adv, input logic [2:0] rsv,
                                                   input logic [NOTE_W-1:0] n,
                                                   input logic [DUR_W-1:0] d);
        return {adv, rsv, n, d};
    endfunction

    function automatic logic [ROM_W-1:0] rom_word(input logic [SONG_W+IDX_W-1:0] a);
        int s;
        int i;
        logic [ROM_W-1:0] w;
        s = int'(a[SONG_W+IDX_W-1:IDX_W]);
        i = int'(a[IDX_W-1:0]);
        w = '0;
        case (s)
            0: if (i == 0) w = make_word(1'b1, 3'd0, 6'd10, 6'd4);
            1: begin
                case (i)
                    0:          w = make_word(1'b0, 3'd0, 6'd20, 6'd8);
                    1:          w = make_word(1'b0, 3'd0, 6'd24, 6'd8);
                    2:          w = make_word(1'b1, 3'd0, 6'd27, 6'd8);
                    3, 4, 5, 6: w = make_word(1'b0, 3'd0, 6'(27 + i), 6'd2);
                    default:    w = '0;
                endcase
            end
            2: w = make_word(1'b1, 3'b101, 6'(i + 1), 6'(i % 7 + 1));
            default: begin
                // Entry 5 is a rest (note 0, non-zero duration), which must not read as END.
                if (i < 20) begin
                    w = make_word(i % 4 == 3, 3'(i % 8),
                                  (i == 5) ? 6'd0 : 6'((i * 7 + 3) % 64), 6'(i % 5 + 1));
                end
            end
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        data_o <= rom_word(addr_i);
    end

endmodule

// File: rtl/chord_song_reader.sv
// Song reader: walks the song ROM and issues up to MAX_VOICES voices per chord to the
// chords block, waiting for player_ready between chords and flagging end of song.
module chord_song_reader
    import chords_pkg::*;
#(
    parameter int  NOTES_PER_SONG = 32,
    parameter int  NUM_SONGS      = 4,
    parameter int  MAX_VOICES     = 3,
    localparam int IDX_W          = $clog2(NOTES_PER_SONG),
    localparam int SONG_W         = $clog2(NUM_SONGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play,
    input  logic [SONG_W-1:0]   song,
    input  logic                player_ready,
    output logic [NOTE_W-1:0]   note,
    output logic [DUR_W-1:0]    duration,
    output logic                new_note,
    output logic [1:0]          voice,
    output logic                song_done,
    output reader_state_e       dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NOTES_PER_SONG - 1);
    localparam logic [1:0]       LAST_VOICE = 2'(MAX_VOICES - 1);

    reader_state_e     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        vcnt_q;
    logic              pend_q;
    logic [SONG_W-1:0] song_q;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;
    logic [1:0]        voice_q;
    logic              new_note_q;
    logic              song_done_q;

    logic [ROM_W-1:0]  rom_data;
    logic              song_chg;
    logic              ready_seen;
    logic              rom_end;
    logic              last_voice;
    logic              unused_rsv;

    song_rom #(
        .IDX_W  (IDX_W),
        .SONG_W (SONG_W)
    ) u_rom (
        .clk    (clk),
        .addr_i ({song, idx_q}),
        .data_o (rom_data)
    );

    assign song_chg   = (song != song_q);
    assign ready_seen = player_ready | pend_q;
    assign rom_end    = is_end_word(rom_data);
    assign last_voice = word_adv(rom_data) | (vcnt_q == LAST_VOICE) | (idx_q == LAST_IDX);
    assign unused_rsv = ^rom_data[14:12];

    // Handshake: new_note is a one-cycle valid with no backpressure; note/duration/voice
    // are valid only in that cycle. player_ready is a one-cycle pulse meaning "chord done"
    // and is honoured only in WAIT_READY (or remembered if it arrives while paused).
    // The ROM word is decoded on the ROMWAIT->ISSUE edge so the strobe coincides with ISSUE;
    // ISSUE then re-reads the same word (address unchanged) to pick the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            vcnt_q      <= '0;
            pend_q      <= 1'b0;
            song_q      <= song;
            note_q      <= '0;
            dur_q       <= '0;
            voice_q     <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            song_q      <= song;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            if (song_chg) begin
                idx_q   <= '0;
                vcnt_q  <= '0;
                pend_q  <= 1'b0;
                state_q <= play ? ST_FETCH : ST_IDLE;
            end else if (!play) begin
                if (player_ready) pend_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE:    state_q <= ST_FETCH;
                    ST_FETCH:   state_q <= ST_ROMWAIT;
                    ST_ROMWAIT: begin
                        if (rom_end) begin
                            song_done_q <= 1'b1;
                        end else begin
                            note_q     <= word_note(rom_data);
                            dur_q      <= word_dur(rom_data);
                            voice_q    <= vcnt_q;
                            new_note_q <= 1'b1;
                        end
                        state_q <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (rom_end) begin
                            state_q <= ST_DONE;
                        end else if (last_voice) begin
                            vcnt_q  <= '0;
                            state_q <= ST_WAIT_READY;
                        end else begin
                            vcnt_q  <= vcnt_q + 2'd1;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_WAIT_READY: begin
                        if (ready_seen) begin
                            pend_q <= 1'b0;
                            if (idx_q == LAST_IDX) begin
                                song_done_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE:  state_q <= ST_DONE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign note      = note_q;
    assign duration  = dur_q;
    assign voice     = voice_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_chord_song_reader.sv
// Bench for chord_song_reader: directed timing scenarios plus randomized play-through of
// whole songs against a transaction-level model of the expected note stream.
module tb_chord_song_reader;
    import chords_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic          player_ready;
    logic [1:0]    song;
    logic [5:0]    note;
    logic [5:0]    duration;
    logic          new_note;
    logic [1:0]    voice;
    logic          song_done;
    reader_state_e dbg_state;

    int errors = 0;
    int checks = 0;

    logic [15:0] tb_rom [4][32];
    // Item layout: {last_of_chord, done, note[5:0], duration[5:0], voice[1:0]}
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    chord_song_reader #(
        .NOTES_PER_SONG (32),
        .NUM_SONGS      (4),
        .MAX_VOICES     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .song         (song),
        .player_ready (player_ready),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .voice        (voice),
        .song_done    (song_done),
        .dbg_state    (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        play = 1'b0;
        player_ready = 1'b0;
        steps(2);
        reset = 1'b0;
        step();
    endtask

    function automatic logic [15:0] mk(input bit adv, input int n, input int d);
        return {adv, 3'b000, 6'(n), 6'(d)};
    endfunction

    function automatic void fill_rom();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++) tb_rom[s][i] = '0;
        tb_rom[0][0] = mk(1, 10, 4);
        tb_rom[1][0] = mk(0, 20, 8);
        tb_rom[1][1] = mk(0, 24, 8);
        tb_rom[1][2] = mk(1, 27, 8);
        for (int i = 3; i <= 6; i++) tb_rom[1][i] = mk(0, 27 + i, 2);
        for (int i = 0; i < 32; i++) tb_rom[2][i] = mk(1, i + 1, i % 7 + 1);
        for (int i = 0; i < 20; i++)
            tb_rom[3][i] = mk(i % 4 == 3, (i == 5) ? 0 : (i * 7 + 3) % 64, i % 5 + 1);
    endfunction

    // Expected note stream of one song: chords of at most three voices, a chord closed by
    // adv, the third voice or the final entry; END or the final chord ends the song.
    function automatic void build_expected(input int s);
        int vc;
        bit last;
        logic [15:0] w;
        vc = 0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            w = tb_rom[s][i];
            if (w[11:0] == 12'd0) begin
                exp_q.push_back(16'h4000);
                return;
            end
            last = w[15] || (vc == 2) || (i == 31);
            exp_q.push_back({last, 1'b0, w[11:6], w[5:0], 2'(vc)});
            vc = last ? 0 : vc + 1;
            if (last && i == 31) exp_q.push_back(16'h4000);
        end
    endfunction

    task automatic test_reset();
        song = 2'd0;
        reset = 1'b1;
        play = 1'b1;
        player_ready = 1'b0;
        steps(3);
        checks++;
        if ({note, duration, voice, new_note, song_done} !== 16'd0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: note=%0d dur=%0d voice=%0d nn=%b done=%b state=%s, required all 0 and IDLE",
                     note, duration, voice, new_note, song_done, dbg_state.name());
        end
        play = 1'b0;
    endtask

    task automatic test_single();
        int seen;
        song = 2'd0;
        do_reset();
        play = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (new_note !== (c == 3)) begin
                errors++;
                $display("FAIL single_latency cycle %0d: new_note=%b required %b", c, new_note, c == 3);
            end
        end
        checks++;
        if ({note, duration, voice} !== {6'd10, 6'd4, 2'd0}) begin
            errors++;
            $display("FAIL single_data: n%0d d%0d v%0d required n10 d4 v0", note, duration, voice);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            seen += int'(new_note) + int'(song_done);
        end
        player_ready = 1'b1;
        step();
        player_ready = 1'b0;
        seen += int'(song_done);
        step();
        seen += int'(song_done);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL single_early_events: got %0d events before song end, required 0", seen);
        end
        step();
        checks++;
        if ({new_note, song_done, note, duration} !== {2'b01, 6'd10, 6'd4}) begin
            errors++;
            $display("FAIL single_done: nn=%b done=%b n%0d d%0d required nn=0 done=1 n10 d4",
                     new_note, song_done, note, duration);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen += int'(new_note) + int'(song_done);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL single_after_done: got %0d events, required 0", seen);
        end
    endtask

    task automatic test_chord_and_forced_last();
        int chord_n[3] = '{20, 24, 27};
        int seen;
        song = 2'd1;
        do_reset();
        play = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++;
            if (new_note !== (c % 3 == 0) ||
                (c % 3 == 0 && {note, duration, voice} !== {6'(chord_n[c / 3 - 1]), 6'd8, 2'(c / 3 - 1)})) begin
                errors++;
                $display("FAIL chord_strobe cycle %0d: nn=%b n%0d d%0d v%0d", c, new_note, note, duration, voice);
            end
            if (c == 9) player_ready = 1'b1;
        end
        step();
        player_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            seen += int'(new_note);
        end
        checks++;
        if (seen != 0 || dbg_state !== ST_WAIT_READY) begin
            errors++;
            $display("FAIL chord_hold: got %0d strobes state=%s, required 0 and WAIT_READY", seen, dbg_state.name());
        end
        player_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            player_ready = 1'b0;
            checks++;
            if (new_note !== (c % 3 == 0) ||
                (c % 3 == 0 && {note, duration, voice} !== {6'(29 + c / 3), 6'd2, 2'(c / 3 - 1)})) begin
                errors++;
                $display("FAIL forced_strobe cycle %0d: nn=%b n%0d d%0d v%0d", c, new_note, note, duration, voice);
            end
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen += int'(new_note);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL forced_last_hold: got %0d strobes, required 0", seen);
        end
        player_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            player_ready = 1'b0;
            checks++;
            if (new_note !== (c == 3) || song_done !== (c == 6) ||
                (c == 3 && {note, voice} !== {6'd33, 2'd0})) begin
                errors++;
                $display("FAIL forced_tail cycle %0d: nn=%b done=%b n%0d v%0d", c, new_note, song_done, note, voice);
            end
        end
    endtask

    task automatic test_pause();
        int seen;
        song = 2'd1;
        do_reset();
        play = 1'b1;
        steps(10);
        play = 1'b0;
        step();
        player_ready = 1'b1;
        step();
        player_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            seen += int'(new_note) + int'(song_done);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL pause_quiet: got %0d events while paused, required 0", seen);
        end
        play = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (new_note !== (c == 3) || (c == 3 && {note, voice} !== {6'd30, 2'd0})) begin
                errors++;
                $display("FAIL pause_resume cycle %0d: nn=%b n%0d v%0d required strobe n30 v0 at cycle 3",
                         c, new_note, note, voice);
            end
        end
    endtask

    task automatic test_song_switch();
        int seen;
        song = 2'd0;
        do_reset();
        play = 1'b1;
        steps(4);
        song = 2'd2;
        player_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            player_ready = 1'b0;
            checks++;
            if (new_note !== (c == 3) || (c == 3 && {note, duration, voice} !== {6'd1, 6'd1, 2'd0})) begin
                errors++;
                $display("FAIL switch_strobe cycle %0d: nn=%b n%0d d%0d v%0d required n1 d1 v0 at cycle 3",
                         c, new_note, note, duration, voice);
            end
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen += int'(new_note);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL switch_ready_ignored: got %0d strobes, required 0", seen);
        end
        play = 1'b0;
        song = 2'd3;
        steps(2);
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL switch_paused_idle: state=%s required IDLE", dbg_state.name());
        end
        play = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (new_note !== (c == 3) || (c == 3 && {note, duration, voice} !== {6'd3, 6'd1, 2'd0})) begin
                errors++;
                $display("FAIL switch_paused_restart cycle %0d: nn=%b n%0d d%0d v%0d required n3 d1 v0",
                         c, new_note, note, duration, voice);
            end
        end
    endtask

    task automatic test_reset_mid();
        song = 2'd1;
        do_reset();
        play = 1'b1;
        steps(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({note, duration, voice, new_note, song_done} !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: n%0d d%0d v%0d nn=%b done=%b required all 0",
                     note, duration, voice, new_note, song_done);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (new_note !== (c == 3) || (c == 3 && {note, voice} !== {6'd20, 2'd0})) begin
                errors++;
                $display("FAIL reset_mid_restart cycle %0d: nn=%b n%0d v%0d required n20 v0 at cycle 3",
                         c, new_note, note, voice);
            end
        end
        steps(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (new_note !== 1'b0 || note !== 6'd0) begin
            errors++;
            $display("FAIL reset_no_partial_strobe: nn=%b n%0d required nn=0 n0", new_note, note);
        end
        play = 1'b0;
    endtask

    task automatic test_random_song(input int s);
        int guard;
        int ready_wait;
        int strobes;
        int exp_strobes;
        int seen;
        bit prev_play;
        logic [15:0] item;
        build_expected(s);
        exp_strobes = 0;
        foreach (exp_q[k]) if (!exp_q[k][14]) exp_strobes++;
        song = 2'(s);
        do_reset();
        play = 1'b1;
        prev_play = 1'b1;
        guard = 0;
        ready_wait = 0;
        strobes = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            step();
            guard++;
            player_ready = 1'b0;
            if (ready_wait > 0) begin
                ready_wait--;
                if (ready_wait == 0) player_ready = 1'b1;
            end
            if (!prev_play) begin
                checks++;
                if (new_note !== 1'b0 || song_done !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_pause_quiet song%0d: nn=%b done=%b required 0 0", s, new_note, song_done);
                end
            end
            if (new_note === 1'b1 || song_done === 1'b1) begin
                item = exp_q.pop_front();
                checks++;
                if (item[14]) begin
                    if ({new_note, song_done} !== 2'b01) begin
                        errors++;
                        $display("FAIL rand_done song%0d: nn=%b done=%b required song_done only", s, new_note, song_done);
                    end
                end else begin
                    strobes++;
                    if ({new_note, song_done, note, duration, voice} !== {2'b10, item[13:0]}) begin
                        errors++;
                        $display("FAIL rand_note song%0d #%0d: nn=%b done=%b n%0d d%0d v%0d required n%0d d%0d v%0d",
                                 s, strobes, new_note, song_done, note, duration, voice,
                                 item[13:8], item[7:2], item[1:0]);
                    end
                    if (item[15]) ready_wait = $urandom_range(1, 4);
                end
                play = 1'b1;
            end else begin
                play = ($urandom_range(0, 7) != 0);
            end
            prev_play = play;
        end
        player_ready = 1'b0;
        play = 1'b1;
        checks++;
        if (exp_q.size() != 0 || strobes != exp_strobes) begin
            errors++;
            $display("FAIL rand_complete song%0d: got %0d strobes with %0d items pending, required %0d strobes",
                     s, strobes, exp_q.size(), exp_strobes);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen += int'(new_note) + int'(song_done);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rand_after_done song%0d: got %0d events, required 0", s, seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        play = 1'b0;
        player_ready = 1'b0;
        song = 2'd0;
        fill_rom();
        test_reset();
        test_single();
        test_chord_and_forced_last();
        test_pause();
        test_song_switch();
        test_reset_mid();
        test_random_song(2);
        test_random_song(3);
        test_random_song(1);
        test_random_song(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
